// File: rtl/wdemux_pkg.sv
// ---------------------------------------------------------------------------
// wdemux_pkg
// Shared definitions for the CONV write-back demultiplexer:
//   - bit positions of the routing info word
//   - frame FSM state encoding
//   - RGB565 field widths used when packing SDRAM pixels
// ---------------------------------------------------------------------------
package wdemux_pkg;

   // Routing info layout: [4] ram_sel, [3] mem_sel (1 = SDRAM), [2:0] channel count
   localparam int RAM_SEL_BIT = 4;
   localparam int MEM_SEL_BIT = 3;
   localparam int CH_LSB      = 0;
   localparam int CH_W        = 3;

   // RGB565 field widths
   localparam int R_W = 5;
   localparam int G_W = 6;
   localparam int B_W = 5;

   // Frame FSM: IDLE waits for a frame start, BUSY is inside a multi-beat frame
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/wdemux_if.sv
// ---------------------------------------------------------------------------
// wdemux_if
// Upstream result stream from the CONV engine into the write-back demux.
//   info          routing info, meaningful on the first beat of a frame
//   base_addr     frame start address, meaningful on the first beat
//   m_data        DN channels of DW bits, channel i at [i*DW +: DW]
//   m_data_first  first beat of a frame
//   m_data_last   last beat of a frame
//   m_data_valid  beat valid
//   m_data_ready  demux can accept the beat
// master: the engine side (drives the beat), slave: the demux side.
// ---------------------------------------------------------------------------
interface wdemux_if #(
   parameter int DW  = 8,
   parameter int DN  = 8,
   parameter int IFW = 5,
   parameter int AW  = 13
) ();

   logic [IFW-1:0]   info;
   logic [AW-1:0]    base_addr;
   logic [DN*DW-1:0] m_data;
   logic             m_data_first;
   logic             m_data_last;
   logic             m_data_valid;
   logic             m_data_ready;

   modport master (
      output info, base_addr, m_data, m_data_first, m_data_last, m_data_valid,
      input  m_data_ready
   );

   modport slave (
      input  info, base_addr, m_data, m_data_first, m_data_last, m_data_valid,
      output m_data_ready
   );

endinterface

// File: rtl/wdemux_axi_frs.sv
// ---------------------------------------------------------------------------
// wdemux_axi_frs
// Full register slice (axi_frs) with a skid stage. Both the output valid/data
// and the upstream ready come straight from flops, so no combinational path
// crosses the slice in either direction, and it sustains one beat per cycle.
//   clk, rst     clock, synchronous active-high reset
//   in_data      upstream payload
//   in_valid     upstream valid
//   in_ready     upstream ready (low while the skid stage is occupied or in reset)
//   out_data     downstream payload, held while out_valid && !out_ready
//   out_valid    downstream valid
//   out_ready    downstream ready
// ---------------------------------------------------------------------------
module wdemux_axi_frs #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   logic [DW-1:0] skid_data;
   logic          skid_valid;

   // Ready only depends on the skid flop; reset forces it low so nothing is
   // accepted in the cycle the reset is sampled.
   assign in_ready = !skid_valid && !rst;

   // The output register takes new data whenever it is empty or being drained.
   // A beat arriving while the output is stalled parks in the skid register,
   // which then refills the output as soon as the sink takes the current beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
      end else if (!skid_valid) begin
         if (!out_valid || out_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
               out_data <= in_data;
            end
         end else if (in_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
         end
      end else if (out_ready) begin
         out_data   <= skid_data;
         skid_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/wdemux.sv
// ---------------------------------------------------------------------------
// wdemux
// Write-back demultiplexer behind the CONV engine. Each frame is steered to
// on-chip feature RAM (all DN channels, channel-masked) or to SDRAM
// (channels 0..2 packed as RGB565), with a running write address per beat.
// Each output path is buffered by a full register slice.
//   clk, rst                         clock, synchronous active-high reset
//   up                               upstream stream (wdemux_if.slave)
//   s_data0/s_ram_sel0/s_addr0       RAM write data, bank select, address
//   s_first0/s_last0/s_valid0        RAM framing and valid, s_ready0 ready
//   s_data1/s_addr1                  SDRAM pixel and address
//   s_first1/s_last1/s_valid1        SDRAM framing and valid, s_ready1 ready
//   err                              sticky framing-error flag
// Build option: WDEMUX_ROUND_EN selects round-to-nearest RGB565 packing
// (saturating); without it the channels are truncated.
// ---------------------------------------------------------------------------
module wdemux
   import wdemux_pkg::*;
#(
   parameter int DW  = 8,
   parameter int DN  = 8,
   parameter int DW1 = 16,
   parameter int IFW = 5,
   parameter int AW  = 13
) (
   input  logic             clk,
   input  logic             rst,
   wdemux_if.slave          up,
   output logic [DN*DW-1:0] s_data0,
   output logic             s_ram_sel0,
   output logic [AW-1:0]    s_addr0,
   output logic             s_first0,
   output logic             s_last0,
   output logic             s_valid0,
   input  logic             s_ready0,
   output logic [DW1-1:0]   s_data1,
   output logic [AW-1:0]    s_addr1,
   output logic             s_first1,
   output logic             s_last1,
   output logic             s_valid1,
   input  logic             s_ready1,
   output logic             err
);

   localparam int W0 = DN*DW + AW + 3;
   localparam int W1 = DW1 + AW + 2;

   state_t           state_q, state_d;
   logic [IFW-1:0]   info_q;
   logic [AW-1:0]    addr_q;
   logic             err_q;

   logic             is_start;
   logic [IFW-1:0]   cur_info;
   logic [AW-1:0]    cur_addr;
   logic             mem_sel;
   logic [CH_W-1:0]  ch_count;
   logic             accept;
   logic [DN*DW-1:0] masked;
   logic [R_W-1:0]   r_f;
   logic [G_W-1:0]   g_f;
   logic [B_W-1:0]   b_f;
   logic [DW1-1:0]   pixel;

   logic             rdy0, rdy1;
   logic [W0-1:0]    out0;
   logic [W1-1:0]    out1;

   // Reduce one channel to a w-bit field. Rounding adds the most significant
   // dropped bit and saturates so 8'hFF stays all-ones.
   function automatic logic [G_W-1:0] pack_field(input logic [DW-1:0] ch, input int w);
      int v;
      v = int'(ch) >> (DW - w);
`ifdef WDEMUX_ROUND_EN
      if (ch[DW-w-1]) begin
         v = v + 1;
      end
      if (v > (1 << w) - 1) begin
         v = (1 << w) - 1;
      end
`endif
      return G_W'(v);
   endfunction

   // A beat opens a frame when it carries first, or when it arrives in IDLE
   // without first (implicit start). Such beats use the live info/base_addr;
   // all others use the values latched at the frame start.
   assign is_start = up.m_data_first || (state_q == IDLE);
   assign cur_info = is_start ? up.info : info_q;
   assign cur_addr = is_start ? up.base_addr : addr_q + AW'(1);
   assign mem_sel  = cur_info[MEM_SEL_BIT];
   assign ch_count = cur_info[CH_LSB +: CH_W];

   // Upstream ready follows the slice the current beat is headed for.
   assign up.m_data_ready = mem_sel ? rdy1 : rdy0;
   assign accept          = up.m_data_valid && up.m_data_ready;

   // Channel mask: count 0 keeps every channel, otherwise only channels below count.
   always_comb begin
      masked = '0;
      for (int i = 0; i < DN; i++) begin
         if (ch_count == '0 || i < int'(ch_count)) begin
            masked[i*DW +: DW] = up.m_data[i*DW +: DW];
         end
      end
   end

   // RGB565 pack of channels 0..2 after masking.
   always_comb begin
      r_f   = R_W'(pack_field(masked[0*DW +: DW], R_W));
      g_f   = pack_field(masked[1*DW +: DW], G_W);
      b_f   = B_W'(pack_field(masked[2*DW +: DW], B_W));
      pixel = {r_f, g_f, b_f};
   end

   // Next frame state: any accepted beat decides the state from its last flag,
   // which covers normal frames, single-beat frames and restarted frames.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = up.m_data_last ? IDLE : BUSY;
      end
   end

   // Frame context: latch info at every frame start, remember the address of
   // the last accepted beat, and flag first-in-BUSY or missing-first-in-IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         info_q  <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q <= cur_addr;
            if (is_start) begin
               info_q <= up.info;
            end
            if ((up.m_data_first && state_q == BUSY) ||
                (!up.m_data_first && state_q == IDLE)) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign err = err_q;

   wdemux_axi_frs #(.DW(W0)) u_ram_slice (
      .clk       (clk),
      .rst       (rst),
      .in_data   ({masked, cur_info[RAM_SEL_BIT], cur_addr, is_start, up.m_data_last}),
      .in_valid  (up.m_data_valid && !mem_sel),
      .in_ready  (rdy0),
      .out_data  (out0),
      .out_valid (s_valid0),
      .out_ready (s_ready0)
   );

   wdemux_axi_frs #(.DW(W1)) u_sdram_slice (
      .clk       (clk),
      .rst       (rst),
      .in_data   ({pixel, cur_addr, is_start, up.m_data_last}),
      .in_valid  (up.m_data_valid && mem_sel),
      .in_ready  (rdy1),
      .out_data  (out1),
      .out_valid (s_valid1),
      .out_ready (s_ready1)
   );

   assign {s_data0, s_ram_sel0, s_addr0, s_first0, s_last0} = out0;
   assign {s_data1, s_addr1, s_first1, s_last1}             = out1;

endmodule

// File: tb/tb_wdemux.sv
// ---------------------------------------------------------------------------
// tb_wdemux
// Self-checking bench for wdemux. Expected beats are queued per output path
// when the driver sees a beat accepted; the output monitor pops and compares
// them, checks stall stability, and flags beats nobody expected.
// ---------------------------------------------------------------------------
module tb_wdemux;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] s_data0;
   logic        s_ram_sel0;
   logic [12:0] s_addr0;
   logic        s_first0, s_last0, s_valid0, s_ready0;
   logic [15:0] s_data1;
   logic [12:0] s_addr1;
   logic        s_first1, s_last1, s_valid1, s_ready1;
   logic        err;

   typedef struct packed {
      logic [63:0] data;
      logic [12:0] addr;
      logic        first;
      logic        last;
      logic        ram_sel;
   } beat_t;

   beat_t q0[$];
   beat_t q1[$];
   int    checks = 0;
   int    errors = 0;
   int    ready_mode = 0;
   logic  held0 = 1'b0;
   beat_t held_val0;

   wdemux_if #(.DW(8), .DN(8), .IFW(5), .AW(13)) up ();

   wdemux dut (
      .clk        (clk),
      .rst        (rst),
      .up         (up),
      .s_data0    (s_data0),
      .s_ram_sel0 (s_ram_sel0),
      .s_addr0    (s_addr0),
      .s_first0   (s_first0),
      .s_last0    (s_last0),
      .s_valid0   (s_valid0),
      .s_ready0   (s_ready0),
      .s_data1    (s_data1),
      .s_addr1    (s_addr1),
      .s_first1   (s_first1),
      .s_last1    (s_last1),
      .s_valid1   (s_valid1),
      .s_ready1   (s_ready1),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Sink model and output monitor: choose the ready for the coming edge,
   // then score whatever will transfer on it.
   always @(negedge clk) begin
      beat_t got0, got1, exp_b;
      case (ready_mode)
         1:       begin s_ready0 = ~s_ready0; s_ready1 = 1'b1; end
         2:       begin s_ready0 = 1'b0;      s_ready1 = 1'b0; end
         default: begin s_ready0 = 1'b1;      s_ready1 = 1'b1; end
      endcase
      got0 = {s_data0, s_addr0, s_first0, s_last0, s_ram_sel0};
      got1 = {48'h0, s_data1, s_addr1, s_first1, s_last1, 1'b0};
      if (rst) begin
         held0 = 1'b0;
      end else begin
         if (held0) begin
            checks++;
            if (s_valid0 !== 1'b1 || got0 !== held_val0) begin
               errors++;
               $display("[TB] FAIL stall_hold got v=%b %h want v=1 %h", s_valid0, got0, held_val0);
            end
         end
         if (s_valid0 === 1'b1 && s_ready0) begin
            checks++;
            if (q0.size() == 0) begin
               errors++;
               $display("[TB] FAIL ram_unexpected got data=%h addr=%h want no beat", s_data0, s_addr0);
            end else begin
               exp_b = q0.pop_front();
               if (got0 !== exp_b) begin
                  errors++;
                  $display("[TB] FAIL ram_beat got data=%h addr=%h f=%b l=%b rs=%b want data=%h addr=%h f=%b l=%b rs=%b",
                           got0.data, got0.addr, got0.first, got0.last, got0.ram_sel,
                           exp_b.data, exp_b.addr, exp_b.first, exp_b.last, exp_b.ram_sel);
               end
            end
         end
         held0     = (s_valid0 === 1'b1) && !s_ready0;
         held_val0 = got0;
         if (s_valid1 === 1'b1 && s_ready1) begin
            checks++;
            if (q1.size() == 0) begin
               errors++;
               $display("[TB] FAIL sdram_unexpected got data=%h addr=%h want no beat", s_data1, s_addr1);
            end else begin
               exp_b = q1.pop_front();
               if (got1 !== exp_b) begin
                  errors++;
                  $display("[TB] FAIL sdram_beat got data=%h addr=%h f=%b l=%b want data=%h addr=%h f=%b l=%b",
                           got1.data[15:0], got1.addr, got1.first, got1.last,
                           exp_b.data[15:0], exp_b.addr, exp_b.first, exp_b.last);
               end
            end
         end
      end
   end

   task automatic send_beat(input logic [63:0] data, input logic first, input logic last,
                            input logic [4:0] inf, input logic [12:0] base,
                            input logic path, input logic [63:0] exp_data,
                            input logic [12:0] exp_addr, input logic exp_first,
                            input logic exp_ram_sel);
      int n;
      @(negedge clk);
      up.m_data       = data;
      up.m_data_first = first;
      up.m_data_last  = last;
      up.info         = inf;
      up.base_addr    = base;
      up.m_data_valid = 1'b1;
      n = 0;
      while (up.m_data_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout got ready=%b want 1", up.m_data_ready);
      end else begin
         @(posedge clk);
         if (path) q1.push_back({exp_data, exp_addr, exp_first, last, 1'b0});
         else      q0.push_back({exp_data, exp_addr, exp_first, last, exp_ram_sel});
      end
   endtask

   task automatic idle_bus();
      @(negedge clk);
      up.m_data_valid = 1'b0;
      up.m_data_first = 1'b0;
      up.m_data_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout got pending=%0d want 0", q0.size() + q1.size());
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      up.m_data       = 64'hDEAD_BEEF_0123_4567;
      up.m_data_first = 1'b1;
      up.m_data_last  = 1'b0;
      up.info         = 5'b0;
      up.base_addr    = 13'h5;
      up.m_data_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({s_valid0, s_valid1, up.m_data_ready, err} !== 4'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got v0=%b v1=%b rdy=%b err=%b want 0 0 0 0",
                  s_valid0, s_valid1, up.m_data_ready, err);
      end
      checks++;
      if ({s_data0, s_addr0, s_first0, s_last0, s_ram_sel0, s_data1, s_addr1, s_first1, s_last1} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data got d0=%h a0=%h d1=%h a1=%h want 0", s_data0, s_addr0, s_data1, s_addr1);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      up.m_data_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (up.m_data_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ready_after_reset got %b want 1", up.m_data_ready);
      end
   endtask

   task automatic test_ram_frame();
      $display("[TB] test_ram_frame");
      for (int i = 0; i < 4; i++) begin
         send_beat(64'hFFFF_FFFF_FFFF_FFFF, i == 0, i == 3, 5'b1_0_011, 13'h100, 1'b0,
                   64'h0000_0000_00FF_FFFF, 13'(13'h100 + i), i == 0, 1'b1);
      end
      idle_bus();
      wait_drain();
   endtask

   task automatic test_sdram_frame();
      logic [15:0] exp_round;
`ifdef WDEMUX_ROUND_EN
      exp_round = 16'h1000;
`else
      exp_round = 16'h0800;
`endif
      $display("[TB] test_sdram_frame");
      send_beat(64'h0000_0000_00F8_FCF8, 1'b1, 1'b0, 5'b0_1_000, 13'h300, 1'b1,
                64'h0000_0000_0000_FFFF, 13'h300, 1'b1, 1'b0);
      send_beat(64'h0000_0000_0000_000C, 1'b0, 1'b1, 5'b0_0_000, 13'h000, 1'b1,
                {48'h0, exp_round}, 13'h301, 1'b0, 1'b0);
      send_beat(64'h0000_0000_00F8_FCF8, 1'b1, 1'b1, 5'b0_1_001, 13'h310, 1'b1,
                64'h0000_0000_0000_F800, 13'h310, 1'b1, 1'b0);
      idle_bus();
      wait_drain();
   endtask

   task automatic test_single_beat();
      $display("[TB] test_single_beat");
      send_beat(64'hAABB_CCDD_1122_3344, 1'b1, 1'b1, 5'b0_0_001, 13'h050, 1'b0,
                64'h0000_0000_0000_0044, 13'h050, 1'b1, 1'b0);
      send_beat(64'h8877_6655_4433_2211, 1'b1, 1'b1, 5'b1_0_111, 13'h060, 1'b0,
                64'h0077_6655_4433_2211, 13'h060, 1'b1, 1'b1);
      idle_bus();
      wait_drain();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_beat_err got %b want 0", err);
      end
   endtask

   task automatic test_backpressure();
      $display("[TB] test_backpressure");
      @(posedge clk);
      #1 ready_mode = 1;
      for (int i = 0; i < 16; i++) begin
         send_beat({8{8'(i + 1)}}, i == 0, i == 15, 5'b0_0_000, 13'h020, 1'b0,
                   {8{8'(i + 1)}}, 13'(13'h020 + i), i == 0, 1'b0);
      end
      idle_bus();
      wait_drain();
      @(posedge clk);
      #1 ready_mode = 0;
   endtask

   task automatic test_addr_wrap();
      $display("[TB] test_addr_wrap");
      for (int i = 0; i < 4; i++) begin
         send_beat(64'h0123_4567_89AB_CDEF ^ 64'(i), i == 0, i == 3, 5'b0_0_000, 13'h1FFE, 1'b0,
                   64'h0123_4567_89AB_CDEF ^ 64'(i), 13'(13'h1FFE + i), i == 0, 1'b0);
      end
      idle_bus();
      wait_drain();
   endtask

   task automatic test_protocol_err();
      $display("[TB] test_protocol_err");
      send_beat(64'h11, 1'b1, 1'b0, 5'b0_0_000, 13'h010, 1'b0, 64'h11, 13'h010, 1'b1, 1'b0);
      send_beat(64'h22, 1'b0, 1'b0, 5'b0_0_000, 13'h000, 1'b0, 64'h22, 13'h011, 1'b0, 1'b0);
      send_beat(64'h33, 1'b1, 1'b0, 5'b0_0_000, 13'h040, 1'b0, 64'h33, 13'h040, 1'b1, 1'b0);
      send_beat(64'h44, 1'b0, 1'b1, 5'b0_0_000, 13'h000, 1'b0, 64'h44, 13'h041, 1'b0, 1'b0);
      idle_bus();
      wait_drain();
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_first_in_busy got %b want 1", err);
      end
      pulse_reset();
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_cleared got %b want 0", err);
      end
      send_beat(64'h55, 1'b0, 1'b1, 5'b0_0_000, 13'h055, 1'b0, 64'h55, 13'h055, 1'b1, 1'b0);
      idle_bus();
      wait_drain();
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_missing_first got %b want 1", err);
      end
      pulse_reset();
   endtask

   task automatic test_reset_mid_frame();
      $display("[TB] test_reset_mid_frame");
      @(posedge clk);
      #1 ready_mode = 2;
      send_beat(64'hA1, 1'b1, 1'b0, 5'b0_0_000, 13'h070, 1'b0, 64'hA1, 13'h070, 1'b1, 1'b0);
      send_beat(64'hA2, 1'b0, 1'b0, 5'b0_0_000, 13'h000, 1'b0, 64'hA2, 13'h071, 1'b0, 1'b0);
      idle_bus();
      pulse_reset();
      q0.delete();
      @(negedge clk);
      checks++;
      if ({s_valid0, s_valid1, err} !== 3'b0 || s_addr0 !== 13'h0 || s_data0 !== 64'h0) begin
         errors++;
         $display("[TB] FAIL mid_reset_out got v0=%b v1=%b err=%b a0=%h d0=%h want 0",
                  s_valid0, s_valid1, err, s_addr0, s_data0);
      end
      @(posedge clk);
      #1 ready_mode = 0;
      for (int i = 0; i < 3; i++) begin
         send_beat(64'hB0 + 64'(i), i == 0, i == 2, 5'b1_0_000, 13'h080, 1'b0,
                   64'hB0 + 64'(i), 13'(13'h080 + i), i == 0, 1'b1);
      end
      idle_bus();
      wait_drain();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset_err got %b want 0", err);
      end
   endtask

   initial begin
      rst             = 1'b1;
      up.m_data_valid = 1'b0;
      up.m_data_first = 1'b0;
      up.m_data_last  = 1'b0;
      up.m_data       = '0;
      up.info         = '0;
      up.base_addr    = '0;
      test_reset();
      test_ram_frame();
      test_sdram_frame();
      test_single_beat();
      test_backpressure();
      test_addr_wrap();
      test_protocol_err();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wdemux.md
# wdemux

Write-back demultiplexer on the output side of the CONV engine. It takes the engine's DN-channel result stream and steers each frame either to on-chip feature RAM (all DN channels, channel-masked) or to SDRAM (channels 0..2 packed as RGB565). For every beat it generates the write address and framing. Each output path is buffered by a full-throughput register slice.

## Interface
Parameters:
- DW, 8, bits per channel
- DN, 8, channels per beat
- DW1, 16, SDRAM pixel width (RGB565)
- IFW, 5, info width: [4] ram_sel, [3] mem_sel (1 = SDRAM), [2:0] channel count (0 = all DN)
- AW, 13, write address width

Ports:
- clk  in  1  clock; the single clock domain
- rst  in  1  reset, synchronous, active-high
- info  in  IFW  routing info, sampled on the first beat
- base_addr  in  AW  frame start address, sampled on the first beat
- m_data  in  DN*DW  result beat, channel i at [i*DW +: DW]
- m_data_first / m_data_last / m_data_valid  in  1  framing and valid
- m_data_ready  out  1  upstream ready
- s_data0  out  DN*DW  RAM write data, channel-masked
- s_ram_sel0  out  1  RAM bank select (latched ram_sel)
- s_addr0  out  AW  RAM write address
- s_first0 / s_last0 / s_valid0  out  1  RAM framing and valid
- s_ready0  in  1  RAM ready
- s_data1  out  DW1  SDRAM pixel
- s_addr1  out  AW  SDRAM write address
- s_first1 / s_last1 / s_valid1  out  1  SDRAM framing and valid
- s_ready1  in  1  SDRAM ready
- err  out  1  sticky framing-error flag

## Operation
- Frame FSM has two states.
  - IDLE -> BUSY on an accepted beat with first=1 and last=0.
  - BUSY -> IDLE on an accepted beat with last=1.
  - A beat with first=1 and last=1 is a single-beat frame; the FSM stays in IDLE.
- On an accepted first beat, info and base_addr are latched.
  - The path select for that beat comes from live info[3].
  - Later beats use the latched value; info changes mid-frame are ignored.
- Address: the first beat uses base_addr. Each later accepted beat uses the previous address + 1, mod 2^AW, so it wraps silently.
- Channel mask: for count n (1..7), channels >= n are forced to 0. Count 0 enables all DN channels.
- SDRAM pack: s_data1 = {ch0[7:3], ch1[7:2], ch2[7:3]}. The channel mask is applied before packing.
- Only the selected path sees valid. m_data_ready = ready of the selected path's slice. The unselected path's valid stays 0.
- first=1 in BUSY (protocol error): treated as a new frame. Info and address are re-latched, and err is set.
- A beat without first in IDLE (protocol error): accepted as an implicit first beat using live info and base_addr; err is set. err clears only on rst.

## Timing
- While rst=1, and in the cycle it is sampled:
  - all s_valid* = 0, s_data*/s_addr*/framing = 0
  - m_data_ready = 0, err = 0
  - FSM = IDLE
- The first cycle after rst deasserts: m_data_ready = 1.
- Latency: an accepted beat appears on the output one cycle later.
- Throughput: 1 beat/cycle with no bubble while the sink holds ready=1.
- Slice handshake: once s_valid* is asserted, it and its data hold stable until s_ready*=1.
- A full slice deasserts m_data_ready combinationally from s_ready* only through the skid stage. No combinational valid path to the outputs.
- rst mid-frame: the in-flight beat is discarded and the FSM returns to IDLE. The next frame must start with first=1; otherwise err is set.

## Configuration
- WDEMUX_ROUND_EN:
  - Defined: SDRAM packing rounds to nearest. The truncated field plus its MSB dropped bit saturates at all-ones, e.g. 8'hFF -> 5'h1F and 8'h0C -> 5'h02.
  - Undefined: plain truncation as in Operation (8'h0C -> 5'h01).
  - The RAM path is unaffected either way.

## Structure
- Shared package holds:
  - info field positions (RAM_SEL_BIT=4, MEM_SEL_BIT=3, CH_LSB=0, CH_W=3)
  - the FSM state encoding (IDLE, BUSY)
  - the RGB565 field widths (5/6/5)
- One sub-module: the existing full register slice axi_frs.
  - RAM path instance: DW = DN*DW+AW+3.
  - SDRAM path instance: DW = DW1+AW+2.
- The FSM, address counter, mask and pack logic live at top level.

## Test plan
- RAM frame: info=5'b1_0_011, base_addr=0x100, 4 beats of 0xFFFF...FF -> s_data0=0x0000_0000_00FF_FFFF, addresses 0x100..0x103, first on beat 0, last on beat 3, s_valid1 never 1.
- SDRAM frame: info[3]=1, beat ch0=0xF8, ch1=0xFC, ch2=0xF8 -> s_data1=0xFFFF; ch0=0x0C, ch1=0, ch2=0 -> 0x0800 (0x1000 with WDEMUX_ROUND_EN).
- Backpressure: s_ready0 toggles 1/0 every cycle over a 16-beat frame -> all 16 beats delivered in order, no duplicates, output stable while stalled.
- Address wrap: base_addr=0x1FFE, 4 beats -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Protocol errors: second first=1 mid-frame with new base 0x40 -> address restarts at 0x40, err=1; beat without first after rst -> accepted at base_addr, err=1.
- Reset mid-frame: rst for 1 cycle after beat 2 -> outputs 0, then a new frame is delivered cleanly with err=0.
